fp_mac_arbiter: RTL and testbench
=================================

FP_MAC_ARBITER -- requirements
Module: fp_mac_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 2, number of requesters sharing one fp8 x fp8 + fp16 -> fp32 adder.
REQ-002 SHALL provide parameter TAG_W, default 4, width of the per-request tag.
REQ-003 SHALL provide parameter ADD_LAT, default 1, adder cycles from issue to registered result.
REQ-004 SHALL provide parameter RSP_DEPTH, default 4, result FIFO entries (power of two).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester operation present.
REQ-008 req_ready  out  NUM_REQ  per-requester operation accepted this cycle.
REQ-009 req_a, req_b  in  8*NUM_REQ each  fp8 operands (sign, 5b exp, 2b mantissa), requester i at [8i+7:8i].
REQ-010 req_c  in  16*NUM_REQ  fp16 addend.
REQ-011 req_tag  in  TAG_W*NUM_REQ  opaque tag, returned unchanged.
REQ-012 add_valid  out  1  issue strobe to adder.
REQ-013 add_fp_1, add_fp_2  out  8 each  fp8 operands to adder.
REQ-014 add_in16  out  16  fp16 addend to adder.
REQ-015 add_result  in  32  fp32 adder result, valid ADD_LAT cycles after add_valid.
REQ-016 rsp_valid / rsp_ready  out / in  1 each  result handshake.
REQ-017 rsp_id  out  clog2(NUM_REQ)  originating requester; rsp_tag  out  TAG_W; rsp_data  out  32.
REQ-018 busy  out  1  high while any operation is in flight or the result FIFO is non-empty.

Function
- REQ-019 SHALL arbitrate round-robin: pointer starts at requester 0; after a grant to i, requester i+1 (mod NUM_REQ) has highest priority.
- REQ-020 SHALL grant at most one requester per cycle; req_ready[i] high only for the granted requester and only when req_valid[i] is high.
- REQ-021 SHALL issue only when credits allow: in_flight + fifo_count < RSP_DEPTH; otherwise all req_ready low and pointer unchanged.
- REQ-022 On grant SHALL drive add_valid=1 and the operands in the same cycle (combinational issue); add_valid=0 otherwise, operands held at last value.
- REQ-023 SHALL carry {id, tag} through an ADD_LAT-deep valid shift pipeline; on pipeline exit SHALL write {id, tag, add_result} into the result FIFO.
- REQ-024 FIFO pops when rsp_valid && rsp_ready; rsp outputs driven from FIFO head; rsp_valid = !empty.
- REQ-025 Simultaneous push and pop SHALL be allowed when full-by-credit; FIFO never overflows because of REQ-021; pointers wrap modulo RSP_DEPTH.
- REQ-026 Results SHALL return in issue order regardless of requester.
- REQ-027 Throughput SHALL be one issue per cycle with rsp_ready held high.

Reset
- REQ-028 On rst SHALL clear: arbiter pointer to 0, pipeline valids, FIFO pointers and count, credit counter; outputs req_ready=0, add_valid=0, rsp_valid=0, busy=0, data outputs 0.
- REQ-029 Reset mid-operation SHALL discard in-flight and buffered results; no response emerges after reset release for pre-reset issues.

Configuration
- REQ-030 With FP_MAC_ARB_STATS_EN defined SHALL add output grant_cnt (16*NUM_REQ), one saturating 16-bit grant counter per requester, reset to 0, incremented on each req_valid&&req_ready.
- REQ-031 Without FP_MAC_ARB_STATS_EN the port and counters SHALL be absent; all other behaviour identical.

Structure
- REQ-032 A shared package fp_mac_pkg SHALL hold fp8/fp16/fp32 field widths and a typedef for the {id, tag, data} result entry.
- REQ-033 The result FIFO SHALL be a sub-module fp_mac_rsp_fifo; arbitration and credit logic stay in the top.

Verification
- REQ-034 Single op: req0 a=0x3C, b=0x3C, c=0x0000, tag=5 -> add_valid same cycle, rsp_valid after ADD_LAT+1 cycles, rsp_id=0, rsp_tag=5, rsp_data=add_result.
- REQ-035 Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_id sequence matches.
- REQ-036 rsp_ready=0, 6 back-to-back requests from req1 -> exactly 4 accepted, req_ready low thereafter; raising rsp_ready one cycle -> one pop, one further accept.
- REQ-037 rst asserted with 2 ops in flight and 1 buffered -> all outputs 0 asynchronously; after release no rsp_valid without new requests.
- REQ-038 With FP_MAC_ARB_STATS_EN: 3 grants to req0, 2 to req1 -> grant_cnt = {16'd2, 16'd3}; counter at 0xFFFF stays 0xFFFF on further grants.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Shared field widths and the result-entry record for the fp8 x fp8 + fp16 MAC arbiter.
package fp_mac_pkg;

  localparam int unsigned FP8_W     = 8;
  localparam int unsigned FP8_EXP_W = 5;
  localparam int unsigned FP8_MAN_W = 2;
  localparam int unsigned FP16_W    = 16;
  localparam int unsigned FP32_W    = 32;

  // Entry fields are sized for the widest supported config; unused upper bits are constant zero.
  localparam int unsigned RSP_ID_MAX_W  = 8;
  localparam int unsigned RSP_TAG_MAX_W = 16;

  typedef struct packed {
    logic [RSP_ID_MAX_W-1:0]  id;
    logic [RSP_TAG_MAX_W-1:0] tag;
    logic [FP32_W-1:0]        data;
  } rsp_entry_t;

endpackage

// File: rtl/fp_mac_rsp_fifo.sv
// Result FIFO (power-of-two depth); head is presented combinationally and reads as zero when empty.
module fp_mac_rsp_fifo
  import fp_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_entry_t push_data,
  input  logic       pop,
  output rsp_entry_t head,
  output logic       empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  rsp_entry_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fp_mac_arbiter.sv
// Round-robin, credit-limited arbiter sharing one fp MAC adder among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define FP_MAC_ARB_STATS_EN.
module fp_mac_arbiter
  import fp_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned ADD_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 4,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [8*NUM_REQ-1:0]     req_a,
  input  logic [8*NUM_REQ-1:0]     req_b,
  input  logic [16*NUM_REQ-1:0]    req_c,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic                     add_valid,
  output logic [7:0]               add_fp_1,
  output logic [7:0]               add_fp_2,
  output logic [15:0]              add_in16,
  input  logic [31:0]              add_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [31:0]              rsp_data,
  output logic                     busy
`ifdef FP_MAC_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]    grant_cnt
`endif
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic              issue;
  logic              pop;
  logic [CW-1:0]     credit_used;
  logic [7:0]        hold_a, hold_b;
  logic [15:0]       hold_c;
  logic [ADD_LAT-1:0] pipe_v;
  logic [ID_W-1:0]   pipe_id  [ADD_LAT];
  logic [TAG_W-1:0]  pipe_tag [ADD_LAT];
  rsp_entry_t        push_data;
  rsp_entry_t        head;
  logic              fifo_empty;
  logic              unused_head;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  // Credits count every issued op until popped, so the FIFO can never overflow.
  assign issue = gnt_any && (credit_used < CW'(RSP_DEPTH)) && !rst;
  assign pop   = rsp_valid && rsp_ready;
  assign busy  = (credit_used != '0);

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  assign add_valid = issue;
  assign add_fp_1  = issue ? req_a[32'(gnt_id)*8 +: 8]   : hold_a;
  assign add_fp_2  = issue ? req_b[32'(gnt_id)*8 +: 8]   : hold_b;
  assign add_in16  = issue ? req_c[32'(gnt_id)*16 +: 16] : hold_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      credit_used <= '0;
      hold_a      <= '0;
      hold_b      <= '0;
      hold_c      <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
        hold_a <= add_fp_1;
        hold_b <= add_fp_2;
        hold_c <= add_in16;
      end
      case ({issue, pop})
        2'b10:   credit_used <= credit_used + CW'(1);
        2'b01:   credit_used <= credit_used - CW'(1);
        default: credit_used <= credit_used;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= issue;
      for (int unsigned i = 1; i < ADD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_id[0]  <= gnt_id;
    pipe_tag[0] <= req_tag[32'(gnt_id)*TAG_W +: TAG_W];
    for (int unsigned i = 1; i < ADD_LAT; i++) begin
      pipe_id[i]  <= pipe_id[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_comb begin
    push_data      = '0;
    push_data.id   = RSP_ID_MAX_W'(pipe_id[ADD_LAT-1]);
    push_data.tag  = RSP_TAG_MAX_W'(pipe_tag[ADD_LAT-1]);
    push_data.data = add_result;
  end

  fp_mac_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_v[ADD_LAT-1]),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign rsp_valid   = !fifo_empty;
  assign rsp_id      = head.id[ID_W-1:0];
  assign rsp_tag     = head.tag[TAG_W-1:0];
  assign rsp_data    = head.data;
  assign unused_head = ^head;

`ifdef FP_MAC_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && grant_cnt[16*i +: 16] != 16'hFFFF)
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_mac_arbiter.sv
// Directed, table-driven bench for fp_mac_arbiter with a registered stand-in adder and a result scoreboard.
module tb_fp_mac_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a, req_b;
  logic [31:0] req_c;
  logic [7:0]  req_tag;
  logic        add_valid;
  logic [7:0]  add_fp_1, add_fp_2;
  logic [15:0] add_in16;
  logic [31:0] add_result;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic        busy;
`ifdef FP_MAC_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  fp_mac_arbiter #(
    .NUM_REQ   (2),
    .TAG_W     (4),
    .ADD_LAT   (1),
    .RSP_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .req_tag    (req_tag),
    .add_valid  (add_valid),
    .add_fp_1   (add_fp_1),
    .add_fp_2   (add_fp_2),
    .add_in16   (add_in16),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_data   (rsp_data),
    .busy       (busy)
`ifdef FP_MAC_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in adder: result = {a, b, c} one cycle after issue, junk otherwise.
  logic [15:0] cyc = '0;
  always @(posedge clk) begin
    cyc <= cyc + 16'd1;
    add_result <= add_valid ? {add_fp_1, add_fp_2, add_in16} : {16'hDEAD, cyc};
  end

  typedef struct {
    logic [1:0]  valid;
    logic        rr;
    logic [7:0]  a, b;
    logic [15:0] c;
    logic [3:0]  tag;
    logic [1:0]  exp_ready;
    logic        exp_rv;
    logic        exp_id;
    logic        exp_busy;
  } vec_t;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [7:0]  last_a = '0, last_b = '0;
  logic [15:0] last_c = '0;
  vec_t        tbl [13];

  function automatic vec_t mk(logic [1:0] v, logic rr, logic [1:0] er, logic erv, logic eid,
                              logic eb, logic [7:0] a, logic [7:0] b, logic [15:0] c, logic [3:0] t);
    vec_t x;
    x.valid = v; x.rr = rr; x.exp_ready = er; x.exp_rv = erv; x.exp_id = eid; x.exp_busy = eb;
    x.a = a; x.b = b; x.c = c; x.tag = t;
    return x;
  endfunction

  function automatic vec_t mkd(logic [1:0] v, logic rr, logic [1:0] er, logic erv, logic eid,
                               logic eb, logic [7:0] a);
    return mk(v, rr, er, erv, eid, eb, a, a ^ 8'h5A, {~a, a}, a[3:0]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({pfx, "_add_valid"}, 32'(add_valid), 32'd0);
    chk({pfx, "_add_ops"},   {add_fp_1, add_fp_2, add_in16}, 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_idtag"}, {27'd0, rsp_id, rsp_tag}, 32'd0);
    chk({pfx, "_rsp_data"},  rsp_data, 32'd0);
    chk({pfx, "_busy"},      32'(busy), 32'd0);
  endtask

  task automatic run_row(input vec_t v);
    exp_t        e;
    int          r;
    logic [7:0]  ea, eb;
    logic [15:0] ec;
    @(negedge clk);
    for (int rq = 0; rq < 2; rq++) begin
      req_a[8*rq +: 8]    = v.a + 8'(rq);
      req_b[8*rq +: 8]    = v.b + 8'(rq);
      req_c[16*rq +: 16]  = v.c + 16'(rq);
      req_tag[4*rq +: 4]  = v.tag + 4'(rq);
    end
    req_valid = v.valid;
    rsp_ready = v.rr;
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    chk("add_valid", 32'(add_valid), 32'(v.exp_ready != 2'b00));
    chk("rsp_valid", 32'(rsp_valid), 32'(v.exp_rv));
    chk("busy",      32'(busy),      32'(v.exp_busy));
    if (v.exp_rv) chk("rsp_id", 32'(rsp_id), 32'(v.exp_id));
    if (v.exp_rv && v.rr) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got response with no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_entry_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_tag",      32'(rsp_tag), 32'(e.tag));
        chk("rsp_data",     rsp_data, e.data);
      end
    end
    if (v.exp_ready != 2'b00) begin
      r  = v.exp_ready[1] ? 1 : 0;
      ea = v.a + 8'(r);
      eb = v.b + 8'(r);
      ec = v.c + 16'(r);
      chk("add_ops", {add_fp_1, add_fp_2, add_in16}, {ea, eb, ec});
      e.id   = v.exp_ready[1];
      e.tag  = v.tag + 4'(r);
      e.data = {ea, eb, ec};
      sb.push_back(e);
      last_a = ea; last_b = eb; last_c = ec;
    end else begin
      chk("add_ops_hold", {add_fp_1, add_fp_2, add_in16}, {last_a, last_b, last_c});
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_tag = '0;

    // single op, then req1 alone to park the pointer at 0, then alternation
    tbl[0]  = mk (2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 16'h0000, 4'd5);
    tbl[1]  = mkd(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h41);
    tbl[2]  = mkd(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h42);
    tbl[3]  = mkd(2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h43);
    tbl[4]  = mkd(2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h44);
    tbl[5]  = mkd(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h45);
    tbl[6]  = mkd(2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h46);
    tbl[7]  = mkd(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h47);
    tbl[8]  = mkd(2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h48);
    tbl[9]  = mkd(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h49);
    tbl[10] = mkd(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h4A);
    tbl[11] = mkd(2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'h4B);
    tbl[12] = mkd(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h4C);

    #1 rst = 1'b1;
    #2 chk_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_row(tbl[i]);

    // credit backpressure: req1 streams with rsp_ready low
    run_row(mkd(2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h80));
    run_row(mkd(2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 8'h81));
    run_row(mkd(2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 8'h82));
    run_row(mkd(2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 8'h83));
    run_row(mkd(2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h84));
    run_row(mkd(2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h85));
    run_row(mkd(2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'h86));
    run_row(mkd(2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 8'h87));
    run_row(mkd(2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h88));
    for (int i = 0; i < 4; i++) run_row(mkd(2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'h90));
    run_row(mkd(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h95));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // reset with two results buffered and one in the adder pipeline
    run_row(mkd(2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'hA0));
    run_row(mkd(2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'hA1));
    run_row(mkd(2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'hA2));
    @(negedge clk);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    sb.delete();
    last_a = '0; last_b = '0; last_c = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) run_row(mkd(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'hB0));

    // three grants to req0, two to req1
    run_row(mkd(2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'hC0));
    run_row(mkd(2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'hC1));
    run_row(mkd(2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'hC2));
    run_row(mkd(2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'hC3));
    run_row(mkd(2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'hC4));
    run_row(mkd(2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'hC5));
    run_row(mkd(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'hC6));
    run_row(mkd(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'hC7));

`ifdef FP_MAC_ARB_STATS_EN
    chk("grant_cnt", grant_cnt, {16'd2, 16'd3});
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    repeat (65540) @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("grant_cnt_sat0", 32'(grant_cnt[15:0]), 32'h0000FFFF);
    chk("grant_cnt_req1", 32'(grant_cnt[31:16]), 32'd2);
    repeat (4) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
